nrisc_ddata_arbiter: RTL and testbench

NRISC_DDATA_ARBITER -- requirements
Module: nrisc_ddata_arbiter

---
 rtl/nrisc_ddata_arbiter_if.sv | 65 ++++++
 rtl/nrisc_ddata_arbiter.sv | 119 +++++++++++
 tb/tb_nrisc_ddata_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nrisc_ddata_arbiter_if.sv
// ---------------------------------------------------------------------------
// nrisc_ddata_arbiter_if
// Bundle of every signal around the D-Data arbiter: the core port, the DMA
// port, the shared load-return path and the single-port memory behind it.
//
// Parameters:
//   TAM      data word width
//   N_DData  D-Data address width
//
// Modports:
//   slave   arbiter view: consumes the master requests and mem_dout, and
//           drives the grants, the rvalids, rdata and every mem_* output
//   master  environment view: drives the requests and mem_dout, and
//           observes everything the arbiter produces
// ---------------------------------------------------------------------------
interface nrisc_ddata_arbiter_if #(
   parameter int TAM     = 16,
   parameter int N_DData = 16
);
   // core master port
   logic               core_req;
   logic [N_DData-1:0] core_addr;
   logic [TAM-1:0]     core_wdata;
   logic               core_we;
   logic [2:0]         core_ctrl;
   logic               core_gnt;

   // DMA master port
   logic               dma_req;
   logic               dma_lock;
   logic [N_DData-1:0] dma_addr;
   logic [TAM-1:0]     dma_wdata;
   logic               dma_we;
   logic [2:0]         dma_ctrl;
   logic               dma_gnt;

   // shared load return
   logic [TAM-1:0]     rdata;
   logic               core_rvalid;
   logic               dma_rvalid;

   // memory side
   logic [N_DData-1:0] mem_addr;
   logic [TAM-1:0]     mem_din;
   logic [2:0]         mem_ctrl;
   logic               mem_load;
   logic               mem_write;
   logic [TAM-1:0]     mem_dout;

   modport slave (
      input  core_req, core_addr, core_wdata, core_we, core_ctrl,
      input  dma_req, dma_lock, dma_addr, dma_wdata, dma_we, dma_ctrl,
      input  mem_dout,
      output core_gnt, dma_gnt, rdata, core_rvalid, dma_rvalid,
      output mem_addr, mem_din, mem_ctrl, mem_load, mem_write
   );

   modport master (
      output core_req, core_addr, core_wdata, core_we, core_ctrl,
      output dma_req, dma_lock, dma_addr, dma_wdata, dma_we, dma_ctrl,
      output mem_dout,
      input  core_gnt, dma_gnt, rdata, core_rvalid, dma_rvalid,
      input  mem_addr, mem_din, mem_ctrl, mem_load, mem_write
   );
endinterface

// File: rtl/nrisc_ddata_arbiter.sv
// ---------------------------------------------------------------------------
// nrisc_ddata_arbiter
// Arbitrates the single D-Data memory port between the CPU core and a DMA
// engine. The core normally wins, but a DMA refused STARVE_MAX cycles in a
// row is forced a grant. A DMA that is granted while asserting dma_lock keeps
// the bus until it drops dma_lock or dma_req. Grants and memory-side signals
// are combinational; load-valid flags are registered (1-cycle load latency).
//
// Parameters:
//   TAM         data word width
//   N_DData     D-Data address width
//   STARVE_MAX  refused DMA cycles before a forced DMA grant (1-255)
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    nrisc_ddata_arbiter_if.slave: core/DMA ports, rdata + rvalids,
//          memory address/data/size and load/store strobes
// ---------------------------------------------------------------------------
module nrisc_ddata_arbiter #(
   parameter int TAM        = 16,
   parameter int N_DData    = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   nrisc_ddata_arbiter_if.slave  bus
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CORE     = 2'd1,
      DMA_LOCK = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] starve_cnt;
   logic       core_gnt;
   logic       dma_gnt;
   logic       core_rvalid_q;
   logic       dma_rvalid_q;

   // Grant decision. Gating with rst_n makes every grant, and therefore every
   // mem_* output, drop to 0 the moment reset asserts, without a clock edge.
   always_comb begin
      core_gnt = 1'b0;
      dma_gnt  = 1'b0;
      if (rst_n) begin
         if (state == DMA_LOCK) begin
            dma_gnt = bus.dma_req;
         end else if (bus.dma_req && (starve_cnt == STARVE_LIM || !bus.core_req)) begin
            dma_gnt = 1'b1;
         end else begin
            core_gnt = bus.core_req;
         end
      end
   end

   // Memory-side mux: the granted master drives the memory, otherwise all 0.
   always_comb begin
      bus.mem_addr  = {N_DData{1'b0}};
      bus.mem_din   = {TAM{1'b0}};
      bus.mem_ctrl  = 3'b000;
      bus.mem_load  = 1'b0;
      bus.mem_write = 1'b0;
      if (core_gnt) begin
         bus.mem_addr  = bus.core_addr;
         bus.mem_din   = bus.core_wdata;
         bus.mem_ctrl  = bus.core_ctrl;
         bus.mem_load  = ~bus.core_we;
         bus.mem_write = bus.core_we;
      end else if (dma_gnt) begin
         bus.mem_addr  = bus.dma_addr;
         bus.mem_din   = bus.dma_wdata;
         bus.mem_ctrl  = bus.dma_ctrl;
         bus.mem_load  = ~bus.dma_we;
         bus.mem_write = bus.dma_we;
      end
   end

   assign bus.core_gnt    = core_gnt;
   assign bus.dma_gnt     = dma_gnt;
   assign bus.rdata       = bus.mem_dout;
   assign bus.core_rvalid = core_rvalid_q;
   assign bus.dma_rvalid  = dma_rvalid_q;

   // State, starvation counter and load-valid flags. The lock is only entered
   // from an actual DMA grant, so a dma_lock raised while the core owns the
   // bus has no effect until the DMA wins normally. Inside DMA_LOCK the state
   // is kept only while the DMA is both requesting and still locking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         starve_cnt    <= 8'd0;
         core_rvalid_q <= 1'b0;
         dma_rvalid_q  <= 1'b0;
      end else begin
         if (dma_gnt && bus.dma_lock) begin
            state <= DMA_LOCK;
         end else if (core_gnt) begin
            state <= CORE;
         end else begin
            state <= IDLE;
         end

         if (dma_gnt || !bus.dma_req) begin
            starve_cnt <= 8'd0;
         end else if (starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
         end

         core_rvalid_q <= core_gnt & ~bus.core_we;
         dma_rvalid_q  <= dma_gnt & ~bus.dma_we;
      end
   end

endmodule

// File: tb/tb_nrisc_ddata_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nrisc_ddata_arbiter
// Directed bench for nrisc_ddata_arbiter with default parameters
// (TAM=16, N_DData=16, STARVE_MAX=4). A table of single-cycle vectors with
// hand-computed outputs is applied first, followed by hand-written sequences
// for starvation, locked bursts, lock exit and reset in the middle of a lock.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_nrisc_ddata_arbiter;

   localparam logic [2:0] CORE_CTRL = 3'b010;
   localparam logic [2:0] DMA_CTRL  = 3'b101;

   typedef struct packed {
      logic        cg;
      logic        dg;
      logic        ld;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic [2:0]  ctrl;
      logic        crv;
      logic        drv;
      logic [15:0] rdata;
   } out_t;

   typedef struct {
      logic        cr;
      logic        cwe;
      logic [15:0] caddr;
      logic [15:0] cwd;
      logic        dr;
      logic        dlk;
      logic        dwe;
      logic [15:0] daddr;
      logic [15:0] dwd;
      logic [15:0] mdout;
      out_t        exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   vecCount;
   int   missCount;
   vec_t vecs[14];

   nrisc_ddata_arbiter_if #(.TAM(16), .N_DData(16)) bus ();

   nrisc_ddata_arbiter #(
      .TAM(16),
      .N_DData(16),
      .STARVE_MAX(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(
      input logic cr, input logic cwe, input logic [15:0] caddr, input logic [15:0] cwd,
      input logic dr, input logic dlk, input logic dwe, input logic [15:0] daddr,
      input logic [15:0] dwd, input logic [15:0] mdout,
      input logic cg, input logic dg, input logic ld, input logic wr,
      input logic [15:0] addr, input logic [15:0] din, input logic [2:0] ctrl,
      input logic crv, input logic drv);
      vec_t v;
      v.cr = cr; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dr = dr; v.dlk = dlk; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
      v.mdout = mdout;
      v.exp.cg = cg; v.exp.dg = dg; v.exp.ld = ld; v.exp.wr = wr;
      v.exp.addr = addr; v.exp.din = din; v.exp.ctrl = ctrl;
      v.exp.crv = crv; v.exp.drv = drv; v.exp.rdata = mdout;
      return v;
   endfunction

   task automatic driveBus(
      input logic cr, input logic cwe, input logic [15:0] caddr, input logic [15:0] cwd,
      input logic dr, input logic dlk, input logic dwe, input logic [15:0] daddr,
      input logic [15:0] dwd, input logic [15:0] mdout);
      bus.core_req   = cr;
      bus.core_we    = cwe;
      bus.core_addr  = caddr;
      bus.core_wdata = cwd;
      bus.core_ctrl  = CORE_CTRL;
      bus.dma_req    = dr;
      bus.dma_lock   = dlk;
      bus.dma_we     = dwe;
      bus.dma_addr   = daddr;
      bus.dma_wdata  = dwd;
      bus.dma_ctrl   = DMA_CTRL;
      bus.mem_dout   = mdout;
   endtask

   task automatic applyStimulus(input vec_t v);
      driveBus(v.cr, v.cwe, v.caddr, v.cwd, v.dr, v.dlk, v.dwe, v.daddr, v.dwd, v.mdout);
   endtask

   function automatic out_t sampleOut();
      out_t o;
      o.cg = bus.core_gnt; o.dg = bus.dma_gnt;
      o.ld = bus.mem_load; o.wr = bus.mem_write;
      o.addr = bus.mem_addr; o.din = bus.mem_din; o.ctrl = bus.mem_ctrl;
      o.crv = bus.core_rvalid; o.drv = bus.dma_rvalid; o.rdata = bus.rdata;
      return o;
   endfunction

   // Full comparison of every arbiter output.
   task automatic checkOutput(input string name, input out_t exp);
      out_t act;
      act = sampleOut();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Comparison of {core_gnt, dma_gnt, core_rvalid, dma_rvalid} only.
   task automatic checkGrants(input string name, input logic cg, input logic dg,
                              input logic crv, input logic drv);
      logic [3:0] act;
      logic [3:0] exp;
      act = {bus.core_gnt, bus.dma_gnt, bus.core_rvalid, bus.dma_rvalid};
      exp = {cg, dg, crv, drv};
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got gnt/rv=%b expected %b", name, act, exp);
      end
   endtask

   initial begin
      out_t zeroOut;
      vecCount  = 0;
      missCount = 0;

      //          cr cwe caddr    cwd      dr dlk dwe daddr    dwd      mdout    | cg dg ld wr addr     din      ctrl      crv drv
      vecs[0]  = mk(1, 0, 16'h0040, 16'h1111, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0040, 16'h1111, CORE_CTRL, 0, 0);
      vecs[1]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'b000,    1, 0);
      vecs[2]  = mk(1, 1, 16'h0080, 16'hCAFE, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0080, 16'hCAFE, CORE_CTRL, 0, 0);
      vecs[3]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0100, 16'h2222, 16'h0000, 0, 1, 1, 0, 16'h0100, 16'h2222, DMA_CTRL,  0, 0);
      vecs[4]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'b000,    0, 1);
      vecs[5]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0200, 16'h5555, 16'h0000, 0, 1, 0, 1, 16'h0200, 16'h5555, DMA_CTRL,  0, 0);
      vecs[6]  = mk(1, 0, 16'h0044, 16'h0A0A, 1, 0, 0, 16'h0300, 16'h3333, 16'h0000, 1, 0, 1, 0, 16'h0044, 16'h0A0A, CORE_CTRL, 0, 0);
      vecs[7]  = mk(1, 1, 16'h0048, 16'h7777, 0, 0, 0, 16'h0000, 16'h0000, 16'h4242, 1, 0, 0, 1, 16'h0048, 16'h7777, CORE_CTRL, 1, 0);
      vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'b000,    0, 0);
      vecs[9]  = mk(1, 0, 16'h0010, 16'h0001, 1, 1, 0, 16'h0020, 16'h0002, 16'h0000, 1, 0, 1, 0, 16'h0010, 16'h0001, CORE_CTRL, 0, 0);
      vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0020, 16'h0002, 16'h5A5A, 0, 1, 1, 0, 16'h0020, 16'h0002, DMA_CTRL,  1, 0);
      vecs[11] = mk(1, 0, 16'h0030, 16'h0003, 1, 0, 0, 16'h0024, 16'h0004, 16'h6B6B, 0, 1, 1, 0, 16'h0024, 16'h0004, DMA_CTRL,  0, 1);
      vecs[12] = mk(1, 0, 16'h0030, 16'h0003, 0, 0, 0, 16'h0000, 16'h0000, 16'h7C7C, 1, 0, 1, 0, 16'h0030, 16'h0003, CORE_CTRL, 0, 1);
      vecs[13] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h8D8D, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'b000,    1, 0);

      // Reset held with a core request pending: nothing may be granted.
      rst_n = 1'b0;
      driveBus(1, 0, 16'h0040, 16'h1111, 1, 1, 0, 16'h0100, 16'h2222, 16'hFFFF);
      #2;
      zeroOut = '0;
      zeroOut.rdata = 16'hFFFF;
      checkOutput("reset_state", zeroOut);
      @(negedge clk);
      #1;
      checkOutput("reset_after_edge", zeroOut);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors, one clock each.
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
         @(negedge clk);
      end

      // Continuous contention: four core grants, then a forced DMA grant.
      for (int i = 0; i < 12; i++) begin
         driveBus(1, 0, 16'h0050, 16'h0000, 1, 0, 0, 16'h0060, 16'h0000, 16'h0000);
         #1;
         checkGrants($sformatf("starve%0d", i), (i % 5) != 4, (i % 5) == 4,
                     (i != 0) && ((i - 1) % 5 != 4), (i != 0) && ((i - 1) % 5 == 4));
         @(negedge clk);
      end
      driveBus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      #1;
      checkGrants("starve_idle", 0, 0, 1, 0);
      @(negedge clk);

      // Locked burst: the core waits out all four beats.
      driveBus(0, 0, 16'h0070, 16'h0000, 1, 1, 0, 16'h0400, 16'h0000, 16'h0000);
      #1; checkGrants("burst_beat1", 0, 1, 0, 0);
      @(negedge clk);
      driveBus(1, 0, 16'h0070, 16'h0000, 1, 1, 0, 16'h0402, 16'h0000, 16'h0000);
      #1; checkGrants("burst_beat2", 0, 1, 0, 1);
      @(negedge clk);
      driveBus(1, 0, 16'h0070, 16'h0000, 1, 1, 0, 16'h0404, 16'h0000, 16'h0000);
      #1; checkGrants("burst_beat3", 0, 1, 0, 1);
      @(negedge clk);
      driveBus(1, 0, 16'h0070, 16'h0000, 1, 0, 0, 16'h0406, 16'h0000, 16'h0000);
      #1; checkGrants("burst_beat4", 0, 1, 0, 1);
      @(negedge clk);
      driveBus(1, 0, 16'h0070, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      #1; checkGrants("burst_core", 1, 0, 0, 1);
      @(negedge clk);
      driveBus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      #1; checkGrants("burst_idle", 0, 0, 1, 0);
      @(negedge clk);

      // Lock released by dropping dma_req: that cycle grants nobody.
      driveBus(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0500, 16'h0000, 16'h0000);
      #1; checkGrants("lockexit_beat1", 0, 1, 0, 0);
      @(negedge clk);
      driveBus(1, 0, 16'h0074, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000);
      #1; checkGrants("lockexit_drop", 0, 0, 0, 1);
      @(negedge clk);
      driveBus(1, 0, 16'h0074, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      #1; checkGrants("lockexit_core", 1, 0, 0, 0);
      @(negedge clk);
      driveBus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      #1; checkGrants("lockexit_idle", 0, 0, 1, 0);
      @(negedge clk);

      // Reset asserted in beat 2 of a locked DMA load burst.
      driveBus(0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0600, 16'h0000, 16'h0000);
      #1; checkGrants("rstlock_beat1", 0, 1, 0, 0);
      @(negedge clk);
      driveBus(1, 0, 16'h0078, 16'h0000, 1, 1, 0, 16'h0602, 16'h0000, 16'h3C3C);
      #1; checkGrants("rstlock_beat2", 0, 1, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      zeroOut = '0;
      zeroOut.rdata = 16'h3C3C;
      checkOutput("rstlock_async", zeroOut);
      @(negedge clk);
      rst_n = 1'b1;
      driveBus(1, 0, 16'h0078, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      #1; checkGrants("rstlock_resume", 1, 0, 0, 0);
      @(negedge clk);
      driveBus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      #1; checkGrants("rstlock_after1", 0, 0, 1, 0);
      @(negedge clk);
      #1; checkGrants("rstlock_after2", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
